// File: rtl/packet_framer_scan.sv
// Per-lane framing scanner: classifies each byte of a beat as TLP/DLLP start, end,
// nullified end or error, carrying packet state and length across beats.
module packet_framer_scan #(
  parameter int LANES    = 64,
  parameter int DLLP_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*LANES-1:0]   data_in,
  input  logic [LANES-1:0]     DK,
  input  logic                 valid_pd,
  input  logic                 linkup,
  input  logic [2:0]           gen,
  output logic [8*LANES-1:0]   data_out,
  output logic [LANES-1:0]     pl_valid,
  output logic [LANES-1:0]     pl_tlpstart,
  output logic [LANES-1:0]     pl_tlpend,
  output logic [LANES-1:0]     pl_tlpedb,
  output logic [LANES-1:0]     pl_dlpstart,
  output logic [LANES-1:0]     pl_dlpend,
  output logic [LANES-1:0]     pl_err,
  output logic                 pl_beat_valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IN_TLP = 2'd1;
  localparam logic [1:0] IN_DLP = 2'd2;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  localparam logic [7:0] DLLP_LEN8 = 8'(DLLP_LEN);

  logic [1:0] state;
  logic [6:0] len;

  logic [1:0]       st;
  logic [6:0]       ln;
  logic [7:0]       byte_v;
  logic [LANES-1:0] v_c, ts_c, te_c, tb_c, ds_c, de_c, er_c;
  logic             gen_ok;

  assign gen_ok = (gen == 3'd0) || (gen == 3'd1);

  // Stage 0: serial lane walk; each byte sees the state left by the previous lane
  always_comb begin
    st     = state;
    ln     = len;
    byte_v = '0;
    v_c    = '0;
    ts_c   = '0;
    te_c   = '0;
    tb_c   = '0;
    ds_c   = '0;
    de_c   = '0;
    er_c   = '0;
    for (int i = 0; i < LANES; i++) begin
      byte_v = data_in[8*i +: 8];
      if (!DK[i]) begin
        if (st != IDLE) begin
          v_c[i] = 1'b1;
          if (ln != 7'd127) ln = ln + 7'd1;
        end
      end else begin
        case (byte_v)
          K_STP, K_SDP: begin
            if (st != IDLE) er_c[i] = 1'b1;
            v_c[i] = 1'b1;
            if (byte_v == K_STP) begin
              ts_c[i] = 1'b1;
              st      = IN_TLP;
            end else begin
              ds_c[i] = 1'b1;
              st      = IN_DLP;
            end
            ln = 7'd1;
          end
          K_END: begin
            if (st == IN_TLP) begin
              te_c[i] = 1'b1;
              v_c[i]  = 1'b1;
            end else if (st == IN_DLP) begin
              de_c[i] = 1'b1;
              v_c[i]  = 1'b1;
              // length includes the END byte itself, computed wide to avoid wrap
              if (({1'b0, ln} + 8'd1) != DLLP_LEN8) er_c[i] = 1'b1;
            end else begin
              er_c[i] = 1'b1;
            end
            st = IDLE;
          end
          K_EDB: begin
            if (st == IN_TLP) begin
              tb_c[i] = 1'b1;
              v_c[i]  = 1'b1;
            end else begin
              er_c[i] = 1'b1;
            end
            st = IDLE;
          end
          default: begin
            if (st != IDLE) er_c[i] = 1'b1;
            st = IDLE;
          end
        endcase
      end
    end
  end

  // Stage 1: registered masks and scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out      <= '0;
      pl_valid      <= '0;
      pl_tlpstart   <= '0;
      pl_tlpend     <= '0;
      pl_tlpedb     <= '0;
      pl_dlpstart   <= '0;
      pl_dlpend     <= '0;
      pl_err        <= '0;
      pl_beat_valid <= 1'b0;
      state         <= IDLE;
      len           <= '0;
    end else begin
      data_out <= data_in;
      if (linkup && gen_ok && valid_pd) begin
        pl_valid      <= v_c;
        pl_tlpstart   <= ts_c;
        pl_tlpend     <= te_c;
        pl_tlpedb     <= tb_c;
        pl_dlpstart   <= ds_c;
        pl_dlpend     <= de_c;
        pl_err        <= er_c;
        pl_beat_valid <= 1'b1;
        state         <= st;
        len           <= ln;
      end else begin
        pl_valid      <= '0;
        pl_tlpstart   <= '0;
        pl_tlpend     <= '0;
        pl_tlpedb     <= '0;
        pl_dlpstart   <= '0;
        pl_dlpend     <= '0;
        pl_err        <= '0;
        pl_beat_valid <= 1'b0;
        if (!linkup || !gen_ok) begin
          state <= IDLE;
          len   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_framer_scan.sv
// Bench for packet_framer_scan at LANES=16: directed framing cases plus random beats
// checked against a packet-level reference model.
module tb_packet_framer_scan;

  localparam int LANES    = 16;
  localparam int DLLP_LEN = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [8*LANES-1:0]   data_in = '0;
  logic [LANES-1:0]     DK = '0;
  logic                 valid_pd = 1'b0;
  logic                 linkup = 1'b0;
  logic [2:0]           gen = 3'd0;
  logic [8*LANES-1:0]   data_out;
  logic [LANES-1:0]     pl_valid, pl_tlpstart, pl_tlpend, pl_tlpedb;
  logic [LANES-1:0]     pl_dlpstart, pl_dlpend, pl_err;
  logic                 pl_beat_valid;

  packet_framer_scan #(.LANES(LANES), .DLLP_LEN(DLLP_LEN)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .DK(DK), .valid_pd(valid_pd),
    .linkup(linkup), .gen(gen), .data_out(data_out), .pl_valid(pl_valid),
    .pl_tlpstart(pl_tlpstart), .pl_tlpend(pl_tlpend), .pl_tlpedb(pl_tlpedb),
    .pl_dlpstart(pl_dlpstart), .pl_dlpend(pl_dlpend), .pl_err(pl_err),
    .pl_beat_valid(pl_beat_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: current packet kind (0 none, 1 TLP, 2 DLLP) and bytes seen so far
  int m_kind = 0;
  int m_len  = 0;
  logic [8*LANES-1:0] e_do;
  logic [LANES-1:0]   e_v, e_ts, e_te, e_tb, e_ds, e_de, e_er;
  logic               e_bv;

  logic [8*LANES-1:0] cd;
  logic [LANES-1:0]   ck;
  logic [7:0]         toks [6];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [127:0] d, input logic [15:0] k,
                            input logic v, input logic lk, input logic r, input logic [2:0] g);
    logic [7:0] b;
    e_v = '0; e_ts = '0; e_te = '0; e_tb = '0; e_ds = '0; e_de = '0; e_er = '0; e_bv = 1'b0;
    if (r) begin
      e_do = '0; m_kind = 0; m_len = 0;
      return;
    end
    e_do = d;
    if (!lk || g > 3'd1) begin
      m_kind = 0; m_len = 0;
      return;
    end
    if (!v) return;
    e_bv = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      b = d[8*i +: 8];
      if (!k[i]) begin
        if (m_kind != 0) begin
          e_v[i] = 1'b1;
          m_len = (m_len >= 127) ? 127 : m_len + 1;
        end
      end else if (b == 8'hFB || b == 8'h5C) begin
        if (m_kind != 0) e_er[i] = 1'b1;
        e_v[i] = 1'b1;
        if (b == 8'hFB) e_ts[i] = 1'b1; else e_ds[i] = 1'b1;
        m_kind = (b == 8'hFB) ? 1 : 2;
        m_len = 1;
      end else if (b == 8'hFD) begin
        if (m_kind == 1) begin e_te[i] = 1'b1; e_v[i] = 1'b1; end
        else if (m_kind == 2) begin
          e_de[i] = 1'b1; e_v[i] = 1'b1;
          if (m_len + 1 != DLLP_LEN) e_er[i] = 1'b1;
        end else e_er[i] = 1'b1;
        m_kind = 0;
      end else if (b == 8'hFE) begin
        if (m_kind == 1) begin e_tb[i] = 1'b1; e_v[i] = 1'b1; end
        else e_er[i] = 1'b1;
        m_kind = 0;
      end else begin
        if (m_kind != 0) e_er[i] = 1'b1;
        m_kind = 0;
      end
    end
  endtask

  task automatic beat(input logic v, input logic lk, input logic r, input logic [2:0] g);
    @(negedge clk);
    data_in = cd; DK = ck; valid_pd = v; linkup = lk; rst = r; gen = g;
    model_step(cd, ck, v, lk, r, g);
    @(posedge clk);
    #1;
    chk("data_out", data_out, e_do);
    chk("pl_valid", pl_valid, e_v);
    chk("tlpstart", pl_tlpstart, e_ts);
    chk("tlpend", pl_tlpend, e_te);
    chk("tlpedb", pl_tlpedb, e_tb);
    chk("dlpstart", pl_dlpstart, e_ds);
    chk("dlpend", pl_dlpend, e_de);
    chk("err", pl_err, e_er);
    chk("beat_valid", pl_beat_valid, e_bv);
  endtask

  task automatic fresh;
    for (int i = 0; i < LANES; i++) cd[8*i +: 8] = 8'($urandom);
    ck = '0;
  endtask

  task automatic putk(input int lane, input logic [7:0] t);
    cd[8*lane +: 8] = t;
    ck[lane] = 1'b1;
  endtask

  initial begin
    toks[0] = 8'hFB; toks[1] = 8'h5C; toks[2] = 8'hFD;
    toks[3] = 8'hFE; toks[4] = 8'hF7; toks[5] = 8'hBC;

    // reset state
    fresh(); beat(1, 1, 1, 3'd0);
    chk("rst_valid", pl_valid, 16'h0);
    chk("rst_dout", data_out, 128'h0);

    // single-beat TLP
    fresh(); putk(0, 8'hFB); putk(15, 8'hFD); beat(1, 1, 0, 3'd0);
    chk("tlp1_valid", pl_valid, 16'hFFFF);
    chk("tlp1_start", pl_tlpstart, 16'h0001);
    chk("tlp1_end", pl_tlpend, 16'h8000);
    chk("tlp1_err", pl_err, 16'h0000);

    // TLP spanning two beats, trailing PAD
    fresh(); putk(0, 8'hFB); beat(1, 1, 0, 3'd1);
    chk("tlp2a_valid", pl_valid, 16'hFFFF);
    fresh(); putk(3, 8'hFD);
    for (int i = 4; i < 16; i++) putk(i, 8'hF7);
    beat(1, 1, 0, 3'd1);
    chk("tlp2b_valid", pl_valid, 16'h000F);
    chk("tlp2b_end", pl_tlpend, 16'h0008);
    chk("tlp2b_err", pl_err, 16'h0000);

    // DLLP of correct and short length
    fresh(); putk(2, 8'h5C); putk(9, 8'hFD); beat(1, 1, 0, 3'd0);
    chk("dllp_start", pl_dlpstart, 16'h0004);
    chk("dllp_end", pl_dlpend, 16'h0200);
    chk("dllp_valid", pl_valid, 16'h03FC);
    chk("dllp_err", pl_err, 16'h0000);
    fresh(); putk(2, 8'h5C); putk(8, 8'hFD); beat(1, 1, 0, 3'd0);
    chk("dllp_short_err", pl_err, 16'h0100);

    // EDB then stray END
    fresh(); putk(0, 8'hFB); putk(7, 8'hFE); putk(9, 8'hFD); beat(1, 1, 0, 3'd0);
    chk("edb_tlpedb", pl_tlpedb, 16'h0080);
    chk("edb_valid", pl_valid, 16'h00FF);
    chk("edb_err", pl_err, 16'h0200);

    // mid-TLP hold, reset, then data only
    fresh(); putk(0, 8'hFB); beat(1, 1, 0, 3'd0);
    fresh(); beat(0, 1, 0, 3'd0);
    chk("hold_bv", pl_beat_valid, 1'b0);
    fresh(); beat(1, 1, 1, 3'd0);
    fresh(); beat(1, 1, 0, 3'd0);
    chk("post_rst_valid", pl_valid, 16'h0);
    chk("post_rst_bv", pl_beat_valid, 1'b1);

    // linkup drop mid-packet
    fresh(); putk(0, 8'hFB); beat(1, 1, 0, 3'd0);
    fresh(); beat(1, 0, 0, 3'd0);
    chk("linkdown_valid", pl_valid, 16'h0);
    fresh(); beat(1, 1, 0, 3'd0);
    chk("after_link_valid", pl_valid, 16'h0);

    // unsupported framing mode
    fresh(); putk(0, 8'hFB); putk(15, 8'hFD); beat(1, 1, 0, 3'd3);
    chk("gen3_valid", pl_valid, 16'h0);
    chk("gen3_dout", data_out, cd);

    // random beats
    for (int n = 0; n < 600; n++) begin
      logic [2:0] g;
      fresh();
      for (int i = 0; i < LANES; i++)
        if ($urandom_range(0, 99) < 20) putk(i, toks[$urandom_range(0, 5)]);
      g = ($urandom_range(0, 99) < 5) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      beat($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 96,
           $urandom_range(0, 99) < 2, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/packet_framer_scan.md
PACKET_FRAMER_SCAN -- requirements
Module: packet_framer_scan

Interface
REQ-001 Parameter LANES, default 64, meaning bytes per beat (1..64); data width is 8*LANES.
REQ-002 Parameter DLLP_LEN, default 8, meaning required DLLP byte count from SDP to END inclusive.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 data_in  input  8*LANES  beat bytes; byte i = data_in[8i+7:8i].
REQ-006 DK  input  LANES  bit i = 1: byte i is a K symbol.
REQ-007 valid_pd  input  1  beat qualifier.
REQ-008 linkup  input  1  link is up.
REQ-009 gen  input  3  0 or 1 means 8b/10b framing; any other value means the framing mode is unsupported.
REQ-010 data_out  output  8*LANES  data_in delayed one cycle.
REQ-011 pl_valid, pl_tlpstart, pl_tlpend, pl_tlpedb, pl_dlpstart, pl_dlpend, pl_err  output  LANES each  per-byte masks, registered.
REQ-012 pl_beat_valid  output  1  the masks refer to a qualified beat.

Function
REQ-013 Framing tokens (DK=1): FB=STP, 5C=SDP, FD=END, FE=EDB, F7=PAD; other K bytes are treated as an idle K.
REQ-014 Scan state SHALL be IDLE, IN_TLP or IN_DLP, with a 7-bit saturating length counter; both are carried across beats.
REQ-015 Bytes are processed lane 0 to lane LANES-1 in order; each byte sees the state left by the byte before it.
REQ-016 STP in IDLE: set tlpstart and valid; go to IN_TLP; len=1.
REQ-017 SDP in IDLE: set dlpstart and valid; go to IN_DLP; len=1.
REQ-018 Data byte (DK=0) in IN_TLP or IN_DLP: set valid; len+1 (saturates at 127).
REQ-019 Data byte in IDLE: no mask bits set.
REQ-020 END in IN_TLP: set tlpend and valid; go to IDLE.
REQ-021 END in IN_DLP: set dlpend and valid; go to IDLE.
REQ-022 END in IN_DLP: additionally set err when len+1 != DLLP_LEN.
REQ-023 EDB in IN_TLP: set tlpedb and valid; go to IDLE.
REQ-024 EDB in IN_DLP: set err; go to IDLE; valid stays 0.
REQ-025 STP or SDP while IN_TLP or IN_DLP: set err on that byte; the old packet is abandoned; the new packet starts as in REQ-016/017.
REQ-026 END or EDB in IDLE: set err only.
REQ-027 PAD or idle K inside a packet: set err; go to IDLE.
REQ-028 PAD or idle K in IDLE: no mask bits set.
REQ-029 Latency: masks, data_out and pl_beat_valid appear exactly 1 cycle after the input beat; there is no backpressure.
REQ-030 Beat with valid_pd=0 and linkup=1: all masks and pl_beat_valid are 0 next cycle; state and len are held.
REQ-031 Beat with linkup=0: all masks and pl_beat_valid are 0 next cycle; state goes to IDLE; len goes to 0.
REQ-032 gen not 0 or 1: all masks and pl_beat_valid are 0; state goes to IDLE.
REQ-033 data_out always registers data_in, regardless of valid_pd, linkup and gen.
REQ-034 Mask exclusivity: tlpstart, tlpend, tlpedb, dlpstart and dlpend are subsets of pl_valid.
REQ-035 pl_err may be set together with dlpend (REQ-022) or with a start bit (REQ-025).

Reset
REQ-036 While rst=1 at a clock edge: data_out=0, all masks=0, pl_beat_valid=0, state=IDLE, len=0.
REQ-037 rst takes priority over every other input, including mid-packet; any packet in progress is discarded, with no err flagged.

Verification
REQ-038 LANES=16, gen=0, one beat: byte0=FB(K), bytes1-14 data, byte15=FD(K) -> next cycle pl_valid=FFFF, tlpstart=0001, tlpend=8000, err=0000.
REQ-039 TLP spanning two beats: beat1 STP at byte0, all other bytes data; beat2 END at byte3 and PAD(K) at bytes4-15 -> beat1 valid=FFFF; beat2 valid=000F, tlpend=0008, err=0.
REQ-040 DLLP: SDP at byte2, 6 data bytes, END at byte9 -> dlpstart=0004, dlpend=0200, valid=03FC, err=0; repeat with 5 data bytes -> END at byte8 and err=0100.
REQ-041 STP at byte0, EDB(K FE) at byte7, END at byte9 -> tlpedb=0080, valid=00FF, err=0200.
REQ-042 Mid-TLP sequence (beat1 = STP plus data): beat2 valid_pd=0 (state held); beat3 rst=1; beat4 data bytes only -> beat4 all masks 0; additionally, linkup=0 mid-packet -> masks 0 and the next beat's data is not marked valid.
REQ-043 gen=3 with REQ-038 stimulus -> all masks 0, pl_beat_valid=0, data_out equal to the input delayed by 1 cycle.
